// File: rtl/adder_4b_pkg.sv
// Shared constants for the 4-bit ADD datapath unit and its siblings.
// Holds the operand width, the register reset values and the ALU op-select codes.
// No logic lives here.
package adder_4b_pkg;

  // Operand and sum width shared by all 4-bit datapath units.
  localparam int ADD_WIDTH = 4;

  // Values the output registers take while rst is high.
  localparam logic [ADD_WIDTH-1:0] RST_OUT  = '0;
  localparam logic                 RST_COUT = 1'b0;
  localparam logic                 RST_OVF  = 1'b0;
  localparam logic                 RST_ZERO = 1'b1;

  // Op-select encoding the control block uses to pick a datapath unit.
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_MULT  = 4'd5,
    OP_SHIFT = 4'd6
  } alu_op_t;

endpackage

// File: rtl/adder_4b_if.sv
// Operand/result bundle between the control block and the ADD unit.
// Master drives operands and carry-in; slave returns registered sum and flags.
// No handshake: a new operand set is consumed every cycle.
interface adder_4b_if
  import adder_4b_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             Cin;
  logic [WIDTH-1:0] out;
  logic             Cout;
  logic             ovf;
  logic             zero;

  modport master (
    output x, y, Cin,
    input  out, Cout, ovf, zero
  );

  modport slave (
    input  x, y, Cin,
    output out, Cout, ovf, zero
  );

endinterface

// File: rtl/adder_4b_full_adder_1b.sv
// One-bit full adder, the ripple-chain cell of adder_4b.
// Latency: purely combinational.
// Backpressure: none.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_4b.sv
// 4-bit ripple-carry adder with carry-in, registered sum, carry, signed overflow and zero flag.
// Latency: exactly 1 cycle from operands to outputs; synchronous active-high reset.
// Backpressure: none, a result is captured on every rising edge.
module adder_4b
  import adder_4b_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  adder_4b_if.slave  bus
);

  // c[i] is the carry into stage i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = bus.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_1b u_fa (
      .a  (bus.x[i]),
      .b  (bus.y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Capture sum and flags each edge; reset wins over any operands in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out  <= RST_OUT;
      bus.Cout <= RST_COUT;
      bus.ovf  <= RST_OVF;
      bus.zero <= RST_ZERO;
    end else begin
      bus.out  <= s;
      bus.Cout <= c[WIDTH];
      // Signed overflow: carry into the sign bit disagrees with carry out of it.
      bus.ovf  <= c[WIDTH] ^ c[WIDTH-1];
      bus.zero <= (s == '0);
    end
  end

endmodule

// File: tb/tb_adder_4b.sv
// Self-checking bench for adder_4b: literal pins, exhaustive sweep and random traffic.
// Reference is plain integer arithmetic on the inputs seen at each rising edge.
// Outputs are compared on every falling edge once the reference holds a value.
module tb_adder_4b;
  import adder_4b_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  adder_4b_if bus ();

  adder_4b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the outputs must hold after the most recent rising edge.
  logic [3:0] m_out;
  logic       m_cout;
  logic       m_ovf;
  logic       m_zero;
  bit         m_vld = 1'b0;
  int         u_sum;
  int         s_sum;
  int         sx;
  int         sy;

  always @(posedge clk) begin
    if (rst) begin
      m_out  = 4'd0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
      m_zero = 1'b1;
    end else begin
      u_sum  = int'(bus.x) + int'(bus.y) + int'(bus.Cin);
      sx     = $signed(bus.x);
      sy     = $signed(bus.y);
      s_sum  = sx + sy + int'(bus.Cin);
      m_out  = 4'(u_sum % 16);
      m_cout = (u_sum >= 16);
      m_ovf  = (s_sum > 7) || (s_sum < -8);
      m_zero = ((u_sum % 16) == 0);
    end
    m_vld = 1'b1;
  end

  // Compare the DUT against the reference away from the active edge.
  always @(negedge clk) begin
    if (m_vld) begin
      chk("model_out",  32'(bus.out),  32'(m_out));
      chk("model_cout", 32'(bus.Cout), 32'(m_cout));
      chk("model_ovf",  32'(bus.ovf),  32'(m_ovf));
      chk("model_zero", 32'(bus.zero), 32'(m_zero));
    end
  end

  // Apply one operand set, let one edge pass, then check hand-computed results.
  task automatic pin(input string name, input logic [3:0] a, input logic [3:0] b, input logic ci,
                     input logic [3:0] eo, input logic ec, input logic eov, input logic ez);
    bus.x   = a;
    bus.y   = b;
    bus.Cin = ci;
    @(posedge clk);
    #1;
    chk({name, "_out"},  32'(bus.out),  32'(eo));
    chk({name, "_cout"}, 32'(bus.Cout), 32'(ec));
    chk({name, "_ovf"},  32'(bus.ovf),  32'(eov));
    chk({name, "_zero"}, 32'(bus.zero), 32'(ez));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    bus.x   = 4'hF;
    bus.y   = 4'hF;
    bus.Cin = 1'b1;

    // Reset held over two edges with live operands.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("rst_out",  32'(bus.out),  32'h0);
      chk("rst_cout", 32'(bus.Cout), 32'h0);
      chk("rst_ovf",  32'(bus.ovf),  32'h0);
      chk("rst_zero", 32'(bus.zero), 32'h1);
    end
    rst = 1'b0;

    pin("first",    4'b1000, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0);
    pin("cin1_a",   4'b1000, 4'b1001, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
    pin("cin1_b",   4'b1101, 4'b0110, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    pin("cin0",     4'b1101, 4'b0110, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0);
    pin("all_ones", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    pin("all_zero", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    pin("wrap",     4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    pin("ovf_pos",  4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);
    pin("ovf_neg",  4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);

    // Every (x, y, Cin) back-to-back, with a one-cycle reset in the middle.
    for (int i = 0; i < 512; i++) begin
      bus.x   = 4'(i);
      bus.y   = 4'(i >> 4);
      bus.Cin = 1'(i >> 8);
      rst     = (i == 300);
      @(posedge clk);
      #1;
      if (i == 300) begin
        chk("mid_rst_out",  32'(bus.out),  32'h0);
        chk("mid_rst_cout", 32'(bus.Cout), 32'h0);
        chk("mid_rst_zero", 32'(bus.zero), 32'h1);
      end
    end
    rst = 1'b0;

    // Random traffic with occasional resets and operand changes mid-cycle.
    for (int j = 0; j < 300; j++) begin
      rst     = ($urandom_range(0, 15) == 0);
      bus.x   = 4'($urandom);
      bus.y   = 4'($urandom);
      bus.Cin = 1'($urandom);
      #5;
      bus.x   = 4'($urandom);
      bus.y   = 4'($urandom);
      bus.Cin = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_4b.md
Name: adder_4b

Overview:
- 4-bit binary adder with carry-in and carry-out, used as the ADD datapath unit beside the other 4-bit logic/arith units (and, or, xor, sub, mult, shift, ...) selected by the control block.
- Sum and carry are computed combinationally by a ripple chain of full adders, then registered on the clock edge.
- Outputs are registered with a 1-cycle latency, and reset is synchronous.

Parameters:
- WIDTH, 4, operand and sum width. Only 4 is required to work; the other parameters are derived from it.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- x  input  4  operand A, unsigned or two's complement.
- y  input  4  operand B.
- Cin  input  1  carry-in, added to the LSB.
- out  output  4  registered sum bits [3:0] of x+y+Cin.
- Cout  output  1  registered carry-out, which is bit 4 of x+y+Cin.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  registered flag, 1 when out == 0.

Behaviour:
- Combinational core:
  - {c4, s[3:0]} = x + y + Cin, computed as a 5-bit result with no truncation before bit 4.
  - Built as a ripple of 4 full adders. For stage i: s_i = x_i ^ y_i ^ c_i, and c_(i+1) = x_i&y_i | c_i&(x_i^y_i), with c_0 = Cin.
- Registering:
  - On each rising clk with rst=0: out<=s, Cout<=c4, ovf<=c3^c4, zero<=(s==0).
  - Latency is exactly 1 cycle. No enable and no handshake: a new result is captured every cycle.
- Reset:
  - On a rising clk with rst=1: out=0, Cout=0, ovf=0, zero=1.
  - Reset overrides any operands applied in the same cycle.
  - Reset asserted mid-stream discards the pending result.
  - The first valid result appears on the first edge after rst deasserts.
- Boundaries:
  - 1111+1111+1 gives out=1111, Cout=1.
  - 0000+0000+0 gives out=0000, Cout=0, zero=1.
  - Wrap-around is modular 2^4, and the lost bit is carried in Cout.
  - ovf is 1 only when both operands have the same sign and the sum sign differs. Example: 0111+0001 gives out=1000, ovf=1, Cout=0.
- Input changes between edges have no effect on the outputs until the next edge.
- X/Z inputs are not required to produce defined outputs.

Decomposition:
- Shared package holds:
  - the operand width constant (4);
  - the reset values (out 0, Cout 0, ovf 0, zero 1);
  - the ALU op-select encoding used by control, if one exists.
- One natural sub-module, full_adder_1b, with ports a, b, ci, s, co. It is instantiated 4 times in a generate loop.
- The register stage lives in adder_4b itself.

Test Plan:
- Reset: hold rst=1 for 2 edges with x=1111, y=1111 -> out=0000, Cout=0, ovf=0, zero=1. Release rst, apply x=1000, y=1001, Cin=0 -> one edge later out=0001, Cout=1, ovf=1.
- Carry-in: x=1000, y=1001, Cin=1 -> out=0010, Cout=1. Then x=1101, y=0110, Cin=1 -> out=0100, Cout=1, ovf=0.
- Cin=0 variant: x=1101, y=0110, Cin=0 -> out=0011, Cout=1, zero=0.
- Extremes:
  - 1111+1111+1 -> out=1111, Cout=1.
  - 0000+0000+0 -> out=0000, zero=1.
  - 1111+0000+1 -> out=0000, Cout=1, zero=1.
- Signed overflow: 0111+0001+0 -> out=1000, Cout=0, ovf=1. 1000+1000+0 -> out=0000, Cout=1, ovf=1.
- Latency/exhaustive: drive all 512 (x, y, Cin) combinations back-to-back, one per cycle. Each output must equal the reference sum of the previous cycle's inputs. Asserting rst mid-sequence must force the reset values on the next edge.
